// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: blank gap, then one lit digit, round robin.
// Value/dp updates are double-buffered and committed at the frame wrap to avoid tearing.
module seg7_scan_ctrl #(
  parameter int NDIG         = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  output logic                ready,
  input  logic [4*NDIG-1:0]   value,
  input  logic [NDIG-1:0]     dp_in,
  input  logic                blank_lz,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [NDIG-1:0]     an
);

  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NDIG);

  localparam logic [CW-1:0]   SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_ONE     = NDIG'(1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  // With no blanking gap the scan goes straight from one lit digit to the next.
  localparam state_t ST_FIRST = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  state_t            state_q;
  logic [IW-1:0]     idx_q;
  logic [CW-1:0]     cnt_q;
  logic [4*NDIG-1:0] shadow_q;
  logic [NDIG-1:0]   shadow_dp_q;
  logic [4*NDIG-1:0] pend_q;
  logic [NDIG-1:0]   pend_dp_q;
  logic              pend_full_q;

  logic              wrap;
  logic [3:0]        nib;
  logic              dig_dp;
  logic              zero_above;
  logic              suppress;
  logic [6:0]        dec;
  logic              show;

  assign wrap = (state_q == ST_SHOW) && (cnt_q == SHOW_LAST) && (idx_q == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FIRST;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_q <= ST_FIRST;
            cnt_q   <= '0;
            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_FIRST;
      endcase

      // Pending is full whenever wrap commits, so commit and accept never coincide.
      if (wrap && pend_full_q) begin
        shadow_q    <= pend_q;
        shadow_dp_q <= pend_dp_q;
        pend_full_q <= 1'b0;
      end else if (load && !pend_full_q) begin
        pend_q      <= value;
        pend_dp_q   <= dp_in;
        pend_full_q <= 1'b1;
      end
    end
  end

  always_comb begin
    nib        = 4'd0;
    dig_dp     = 1'b0;
    zero_above = 1'b1;
    suppress   = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above = zero_above && (shadow_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        nib      = shadow_q[4*i +: 4];
        dig_dp   = shadow_dp_q[i];
        suppress = blank_lz && (i > 0) && zero_above;
      end
    end
  end

  always_comb begin
    case (nib)
      4'd0:    dec = 7'h7E;
      4'd1:    dec = 7'h30;
      4'd2:    dec = 7'h6D;
      4'd3:    dec = 7'h79;
      4'd4:    dec = 7'h33;
      4'd5:    dec = 7'h5B;
      4'd6:    dec = 7'h5F;
      4'd7:    dec = 7'h70;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h73;
      default: dec = 7'h00;
    endcase
  end

  assign show  = (state_q == ST_SHOW);
  assign an    = show ? (AN_ONE << idx_q) : '0;
  assign seg   = (show && !suppress) ? dec : 7'h00;
  assign dp    = show && dig_dp;
  assign ready = !pend_full_q;

endmodule
